// File: rtl/dot_prod_peak.sv
// dot_prod_peak
//   Peak search stage behind the pipelined complex dot product in the CAF
//   search path. Each accepted product (one per lag/frequency bin) is tagged
//   with its position in the current frame. A three-stage pipeline then
//   computes |x|^2 = I^2 + Q^2 and tracks the largest value over `length`
//   consecutive products. At frame end the peak magnitude, its index and the
//   complex sample that produced it are presented under valid/ready.
//
// Ports
//   clk                    : single clock, rising edge
//   rst                    : synchronous, active-high reset
//   m_axis_product_tvalid  : upstream product valid
//   i, q                   : signed product I / Q
//   s_axis_product_tready  : product accepted this cycle (when valid)
//   m_axis_peak_tready     : consumer takes the peak result
//   s_axis_peak_tvalid     : peak result valid
//   peak_mag               : unsigned I^2+Q^2 of the peak
//   peak_index             : position of the peak in the frame, 0..length-1
//   peak_i, peak_q         : complex value at the peak
module dot_prod_peak #(
  parameter int i_bits     = 24,
  parameter int q_bits     = 24,   // must equal i_bits
  parameter int mag_bits   = 49,   // 2*i_bits+1
  parameter int length     = 16,   // products per frame, >= 4
  parameter int index_bits = 4     // 2**index_bits >= length
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_axis_product_tvalid,
  input  logic signed [i_bits-1:0]     i,
  input  logic signed [q_bits-1:0]     q,
  output logic                         s_axis_product_tready,
  input  logic                         m_axis_peak_tready,
  output logic                         s_axis_peak_tvalid,
  output logic        [mag_bits-1:0]   peak_mag,
  output logic        [index_bits-1:0] peak_index,
  output logic signed [i_bits-1:0]     peak_i,
  output logic signed [q_bits-1:0]     peak_q
);

  localparam logic [index_bits-1:0] last_index = index_bits'(length - 1);

  logic                        accept;
  logic [index_bits-1:0]       frame_count;

  // S1: squares plus side-band data
  logic                        s1_valid;
  logic [2*i_bits-1:0]         s1_sq_i;
  logic [2*q_bits-1:0]         s1_sq_q;
  logic [index_bits-1:0]       s1_index;
  logic signed [i_bits-1:0]    s1_i;
  logic signed [q_bits-1:0]    s1_q;
  logic                        s1_last;

  // S2: magnitude plus side-band data
  logic                        s2_valid;
  logic [mag_bits-1:0]         s2_mag;
  logic [index_bits-1:0]       s2_index;
  logic signed [i_bits-1:0]    s2_i;
  logic signed [q_bits-1:0]    s2_q;
  logic                        s2_last;

  // S3: running maximum for the frame in progress
  logic [mag_bits-1:0]         max_mag;
  logic [index_bits-1:0]       max_index;
  logic signed [i_bits-1:0]    max_i;
  logic signed [q_bits-1:0]    max_q;

  logic signed [2*i_bits-1:0]  sq_i_full;
  logic signed [2*q_bits-1:0]  sq_q_full;
  logic                        take;
  logic [mag_bits-1:0]         win_mag;
  logic [index_bits-1:0]       win_index;
  logic signed [i_bits-1:0]    win_i;
  logic signed [q_bits-1:0]    win_q;

  // Only the last product of a frame can stall, and only while the previous
  // result is still waiting: every other product finishes before the next
  // result write, so the single output register is never overwritten.
  assign s_axis_product_tready =
    !(s_axis_peak_tvalid && !m_axis_peak_tready && (frame_count == last_index));
  assign accept = m_axis_product_tvalid && s_axis_product_tready;

  // Signed squares are non-negative, so the full-width product reads as unsigned.
  assign sq_i_full = i * i;
  assign sq_q_full = q * q;

  // Index 0 starts a new frame and loads unconditionally; afterwards only a
  // strictly larger magnitude replaces the max, so ties keep the earliest index.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    take      = 1'b0;
    win_mag   = max_mag;
    win_index = max_index;
    win_i     = max_i;
    win_q     = max_q;
    if (s2_valid && ((s2_index == '0) || (s2_mag > max_mag))) begin
      take      = 1'b1;
      win_mag   = s2_mag;
      win_index = s2_index;
      win_i     = s2_i;
      win_q     = s2_q;
    end
  end

  // Control and result state: cleared by reset so a partial frame is dropped.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count        <= '0;
      s1_valid           <= 1'b0;
      s2_valid           <= 1'b0;
      max_mag            <= '0;
      max_index          <= '0;
      max_i              <= '0;
      max_q              <= '0;
      s_axis_peak_tvalid <= 1'b0;
      peak_mag           <= '0;
      peak_index         <= '0;
      peak_i             <= '0;
      peak_q             <= '0;
    end else begin
      if (accept) begin
        frame_count <= (frame_count == last_index) ? '0
                                                   : frame_count + index_bits'(1);
      end
      s1_valid <= accept;
      s2_valid <= s1_valid;

      if (take) begin
        max_mag   <= win_mag;
        max_index <= win_index;
        max_i     <= win_i;
        max_q     <= win_q;
      end

      // A new result wins over a same-cycle acceptance of the old one.
      if (s2_valid && s2_last) begin
        s_axis_peak_tvalid <= 1'b1;
        peak_mag           <= win_mag;
        peak_index         <= win_index;
        peak_i             <= win_i;
        peak_q             <= win_q;
      end else if (s_axis_peak_tvalid && m_axis_peak_tready) begin
        s_axis_peak_tvalid <= 1'b0;
      end
    end
  end

  // Pipeline data registers: qualified by the stage valids, so no reset.
  // NOTE: data-only registers stay out of the reset branch; their contents
  // are ignored until the matching valid bit is set.
  always_ff @(posedge clk) begin
    s1_sq_i  <= sq_i_full;
    s1_sq_q  <= sq_q_full;
    s1_index <= frame_count;
    s1_i     <= i;
    s1_q     <= q;
    s1_last  <= (frame_count == last_index);

    // Sum peaks at 2^(2*i_bits-1); the extra top bit keeps it from wrapping.
    s2_mag   <= mag_bits'(s1_sq_i) + mag_bits'(s1_sq_q);
    s2_index <= s1_index;
    s2_i     <= s1_i;
    s2_q     <= s1_q;
    s2_last  <= s1_last;
  end

endmodule

// File: tb/tb_dot_prod_peak.sv
// tb_dot_prod_peak
//   Directed bench for dot_prod_peak with a 4-product frame. Each completed
//   frame pushes its expected peak (computed by a plain argmax over the frame)
//   into a scoreboard; a monitor compares held results and pops on handshake.
module tb_dot_prod_peak;

  localparam int i_bits     = 24;
  localparam int q_bits     = 24;
  localparam int mag_bits   = 49;
  localparam int length     = 4;
  localparam int index_bits = 2;

  typedef struct {
    logic [mag_bits-1:0]   mag;
    logic [index_bits-1:0] idx;
    logic [i_bits-1:0]     i;
    logic [q_bits-1:0]     q;
  } peak_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  prod_valid;
  logic [i_bits-1:0]     pi;
  logic [q_bits-1:0]     pq;
  logic                  prod_ready;
  logic                  peak_ready;
  logic                  peak_valid;
  logic [mag_bits-1:0]   peak_mag;
  logic [index_bits-1:0] peak_index;
  logic [i_bits-1:0]     peak_i;
  logic [q_bits-1:0]     peak_q;

  peak_t             sb[$];
  int                pop_cyc[$];
  int                total   = 0;
  int                bad     = 0;
  int                results = 0;
  int                cyc     = 0;
  logic [i_bits-1:0] fr_i[length];
  logic [q_bits-1:0] fr_q[length];
  int                fr_n = 0;

  dot_prod_peak #(
    .i_bits(i_bits), .q_bits(q_bits), .mag_bits(mag_bits),
    .length(length), .index_bits(index_bits)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .m_axis_product_tvalid (prod_valid),
    .i                     (pi),
    .q                     (pq),
    .s_axis_product_tready (prod_ready),
    .m_axis_peak_tready    (peak_ready),
    .s_axis_peak_tvalid    (peak_valid),
    .peak_mag              (peak_mag),
    .peak_index            (peak_index),
    .peak_i                (peak_i),
    .peak_q                (peak_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: first strictly-largest magnitude in the frame.
  function automatic peak_t model();
    peak_t  p;
    longint best = -1;
    longint si, sq, m;
    p.mag = '0; p.idx = '0; p.i = '0; p.q = '0;
    for (int k = 0; k < length; k++) begin
      si = longint'($signed(fr_i[k]));
      sq = longint'($signed(fr_q[k]));
      m  = si * si + sq * sq;
      if (m > best) begin
        best  = m;
        p.mag = best[mag_bits-1:0];
        p.idx = index_bits'(k);
        p.i   = fr_i[k];
        p.q   = fr_q[k];
      end
    end
    return p;
  endfunction

  task automatic record(input logic [i_bits-1:0] iv, input logic [q_bits-1:0] qv);
    fr_i[fr_n] = iv;
    fr_q[fr_n] = qv;
    fr_n++;
    if (fr_n == length) begin
      sb.push_back(model());
      fr_n = 0;
    end
  endtask

  // Drive one product and wait (bounded) for its acceptance; returns at edge+1.
  task automatic send(input string tag, input logic [i_bits-1:0] iv, input logic [q_bits-1:0] qv);
    int stalls = 0;
    prod_valid = 1'b1;
    pi = iv;
    pq = qv;
    @(negedge clk);
    while (!prod_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    check({tag, "_stall"}, 64'(stalls), 64'd0);
    if (prod_ready) begin
      @(posedge clk);
      #1;
      record(iv, qv);
    end
    prod_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: any valid result must match the scoreboard head, held or taken.
  always @(negedge clk) begin
    if (!rst && peak_valid) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL spurious_tvalid: observed=1 expected=0");
      end
      if (sb.size() != 0) begin
        check("peak_mag",   64'(peak_mag),   64'(sb[0].mag));
        check("peak_index", 64'(peak_index), 64'(sb[0].idx));
        check("peak_i",     64'(peak_i),     64'(sb[0].i));
        check("peak_q",     64'(peak_q),     64'(sb[0].q));
        if (peak_ready) begin
          void'(sb.pop_front());
          results++;
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  initial begin
    int n;
    int spacing;
    rst        = 1'b1;
    prod_valid = 1'b0;
    pi         = '0;
    pq         = '0;
    peak_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_prod_ready", 64'(prod_ready), 64'd1);
    check("rst_tvalid",     64'(peak_valid), 64'd0);
    check("rst_mag",        64'(peak_mag),   64'd0);
    check("rst_index",      64'(peak_index), 64'd0);
    check("rst_i",          64'(peak_i),     64'd0);
    check("rst_q",          64'(peak_q),     64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic frame, tie at index 3 goes to index 1; latency and one-cycle valid
    send("t1", 24'(3), 24'(4));
    send("t1", 24'(-6), 24'(8));
    send("t1", 24'(1), 24'(1));
    send("t1", 24'(0), 24'(-10));
    check("t1_exp_mag", 64'(sb[0].mag), 64'd100);
    @(negedge clk); check("t1_lat1", 64'(peak_valid), 64'd0);
    @(negedge clk); check("t1_lat2", 64'(peak_valid), 64'd0);
    @(negedge clk); check("t1_lat3", 64'(peak_valid), 64'd1);
    check("t1_index", 64'(peak_index), 64'd1);
    @(negedge clk); check("t1_onecyc", 64'(peak_valid), 64'd0);
    drain("t1");

    // Extremes: -2^23 squared twice, no wrap
    send("ext", 24'(1), 24'(1));
    send("ext", 24'(2), 24'(-2));
    send("ext", 24'h800000, 24'h800000);
    send("ext", 24'(5), 24'(0));
    check("ext_exp_mag", 64'(sb[0].mag), 64'h8000_0000_0000);
    drain("ext");

    // Back-to-back frames, peaks at index 0 then 3
    pop_cyc.delete();
    send("bb", 24'(100), 24'(0));
    send("bb", 24'(3), 24'(3));
    send("bb", 24'(-99), 24'(5));
    send("bb", 24'(0), 24'(7));
    send("bb", 24'(1), 24'(2));
    send("bb", 24'(-3), 24'(0));
    send("bb", 24'(2), 24'(2));
    send("bb", 24'(50), 24'(-60));
    drain("bb");
    check("bb_count", 64'(pop_cyc.size()), 64'd2);
    spacing = (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : -1;
    check("bb_spacing", 64'(spacing), 64'd4);

    // Backpressure: frame A held, frame B stalls at its last product
    peak_ready = 1'b0;
    send("bpa", 24'(10), 24'(0));
    send("bpa", 24'(0), 24'(20));
    send("bpa", 24'(15), 24'(15));
    send("bpa", 24'(-1), 24'(3));
    n = 0;
    while (!peak_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_a_valid", 64'(peak_valid), 64'd1);
    @(posedge clk);
    #1;
    send("bpb", 24'(4), 24'(4));
    send("bpb", 24'(9), 24'(-9));
    send("bpb", 24'(0), 24'(0));
    prod_valid = 1'b1;
    pi = 24'(-12);
    pq = 24'(1);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 64'(prod_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    peak_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_back", 64'(prod_ready), 64'd1);
    @(posedge clk);
    #1;
    record(24'(-12), 24'(1));
    prod_valid = 1'b0;
    @(negedge clk); check("bp_lat1", 64'(peak_valid), 64'd0);
    @(negedge clk); check("bp_lat2", 64'(peak_valid), 64'd0);
    @(negedge clk); check("bp_lat3", 64'(peak_valid), 64'd1);
    drain("bp");

    // Reset after two products: they are discarded, next frame starts at 0
    send("rm", 24'(1000), 24'(1000));
    send("rm", 24'(2000), 24'(2000));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    fr_n = 0;
    @(negedge clk);
    check("rm_tvalid", 64'(peak_valid), 64'd0);
    check("rm_ready",  64'(prod_ready), 64'd1);
    @(posedge clk);
    #1;
    send("rm", 24'(1), 24'(0));
    send("rm", 24'(-8), 24'(1));
    send("rm", 24'(0), 24'(9));
    send("rm", 24'(3), 24'(-3));
    drain("rm");

    // All-zero frame
    repeat (length) send("zero", 24'(0), 24'(0));
    drain("zero");

    repeat (10) @(negedge clk);
    check("results", 64'(results), 64'd8);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_prod_peak.md
# dot_prod_peak

Downstream stage of the pipelined complex dot product in the CAF search path. Consumes the stream of complex dot-product results (one per lag/frequency bin), computes the magnitude squared of each, and tracks the maximum over a frame of `length` consecutive products. At frame end it emits the peak magnitude, its index within the frame, and the complex value that produced it, under a valid/ready handshake. The peak register holds one result and back-pressures the product stream only when a second frame would complete before the held result is taken.

## Interface
- `i_bits`, 24, width of signed product I input.
- `q_bits`, 24, width of signed product Q input; must equal `i_bits`.
- `mag_bits`, 49, magnitude width, fixed at 2*`i_bits`+1.
- `length`, 16, products per search frame; must be ≥4.
- `index_bits`, 4, peak index width; 2^`index_bits` ≥ `length`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `m_axis_product_tvalid` in 1: upstream product valid.
- `i` in `i_bits`: signed product I.
- `q` in `q_bits`: signed product Q.
- `s_axis_product_tready` out 1: block accepts a product this cycle.
- `m_axis_peak_tready` in 1: consumer accepts the peak result.
- `s_axis_peak_tvalid` out 1: peak result valid.
- `peak_mag` out `mag_bits`: unsigned I²+Q² of the peak.
- `peak_index` out `index_bits`: position of the peak in the frame, 0..`length`-1.
- `peak_i` out `i_bits`, `peak_q` out `q_bits`: complex value at the peak.

## Operation
- Accept: product taken when `m_axis_product_tvalid` && `s_axis_product_tready`.
- `frame_count` (0..`length`-1) tags each accepted product with its index. It increments per accept and wraps to 0 after `length`-1.
- Pipeline, advanced unconditionally with a valid bit per stage:
  - S1 registers the signed squares i*i and q*q (each 2*`i_bits` bits, unsigned result), plus the index, i, q, and a last-of-frame flag.
  - S2 registers mag = sq_i + sq_q, zero-extended to `mag_bits`. No overflow is possible: the maximum is 2^(2*`i_bits`-1).
  - S3 compares and updates:
    - First element of a frame (index 0): loads the running max unconditionally.
    - Otherwise: updates only on strictly greater mag. On ties, the earliest index wins.
- Frame end: when S2 carries the last-of-frame flag, S3 writes the final winner (including the S2 element if it wins) into the output registers and sets `s_axis_peak_tvalid`.
- The output holds stable until `m_axis_peak_tready` is high. `s_axis_peak_tvalid` clears on acceptance, unless a new result is written in the same cycle, in which case it stays high with the new data.
- Ready rule:
  - `s_axis_product_tready` = !(`s_axis_peak_tvalid` && !`m_axis_peak_tready` && `frame_count`==`length`-1).
  - Only the final product of a frame stalls, and only while a prior result is still held.
  - Because `length` ≥4 exceeds the pipeline depth, no result is ever overwritten.
- Reset: clears `frame_count`, all stage valids, the running max, `s_axis_peak_tvalid`, `peak_mag`, `peak_index`, `peak_i` and `peak_q` to 0. Any partial frame is discarded, and the next accepted product is index 0.

## Timing
- Reset values: `s_axis_product_tready`=1, all other outputs 0.
- Latency: if the final product of a frame is accepted in cycle t, `s_axis_peak_tvalid` is high from cycle t+3.
- Throughput: one product per cycle sustained. Back-to-back frames produce one result every `length` cycles when the consumer is always ready.
- Simultaneous output accept and new result write in the same cycle: the new result wins and `tvalid` stays high.
- `rst` asserted mid-pipeline: in-flight products are dropped and no result is emitted for them.
- `s_axis_product_tready` is combinational from `m_axis_peak_tready` and registered state only. It has no dependence on `m_axis_product_tvalid`.

## Test plan
- Frame `length`=4 of (3,4), (-6,8), (1,1), (0,-10), valid every cycle, consumer ready -> 3 cycles after the last accept: `peak_mag`=100, `peak_index`=1, `peak_i`=-6, `peak_q`=8 (tie with index 3 resolved to the earliest), `tvalid` high for one cycle.
- Extremes: `i`=`q`=-2^23 at index 2, other products small -> `peak_mag`=2^47, `peak_index`=2, no wrap.
- Back-to-back frames of continuous valid with peaks at indices 0 then 3 -> results every 4 cycles with indices 0, 3; `s_axis_product_tready` never drops.
- Backpressure: `m_axis_peak_tready`=0 while a second frame streams in -> ready drops only at that frame's index-3 product. Releasing ready -> first result is accepted, the stalled product is taken, and the second result appears 3 cycles later, correct and intact.
- `rst` pulsed after 2 products of a frame -> no result from them. The next 4 products form a fresh frame with indices 0..3 and the correct peak.
- All-zero frame -> `peak_mag`=0, `peak_index`=0, `peak_i`=`peak_q`=0.
